// File: rtl/trafficlight_ew.sv
// -----------------------------------------------------------------------------
// trafficlight_ew
//
// East-West traffic light controller. Runs the complementary half of a
// 36-cycle phase plan shared with the North-South light: East-West shows red
// while North-South cycles left/green/yellow, and vice versa. Supports
// emergency preemption (ALLSTOP) with exact resume of the interrupted phase,
// and a conflict monitor that latches a flashing-red FAULT if both approaches
// ever show a non-red aspect at the same time.
//
// Ports:
//   clk        in   1  clock, all state changes on the rising edge
//   rst_n      in   1  asynchronous active-low reset
//   emergency  in   1  emergency vehicle present, sampled on clk rising edge
//   ns_out     in   4  North-South light drive, same encoding as out
//   out        out  4  light drive: [3] left, [2] green, [1] yellow, [0] red
//   phase      out  3  state: RED=0 LEFT=1 GREEN=2 YELLOW=3 ALLSTOP=4 FAULT=5
//   conflict   out  1  sticky fault flag, cleared only by reset
// -----------------------------------------------------------------------------
module trafficlight_ew #(
    parameter int RED_CYC    = 18,
    parameter int LEFT_CYC   = 5,
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emergency,
    input  logic [3:0] ns_out,
    output logic [3:0] out,
    output logic [2:0] phase,
    output logic       conflict
);

    typedef enum logic [2:0] {
        S_RED     = 3'd0,
        S_LEFT    = 3'd1,
        S_GREEN   = 3'd2,
        S_YELLOW  = 3'd3,
        S_ALLSTOP = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYC - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(LEFT_CYC - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);

    localparam logic [3:0] ASPECT_RED    = 4'b0001;
    localparam logic [3:0] ASPECT_LEFT   = 4'b1001;
    localparam logic [3:0] ASPECT_GREEN  = 4'b0100;
    localparam logic [3:0] ASPECT_YELLOW = 4'b0010;

    state_t           state, state_n;
    logic [CNT_W-1:0] counter, counter_n;
    state_t           saved_state, saved_state_n;
    logic [CNT_W-1:0] saved_cnt, saved_cnt_n;
    logic             blink, blink_n;

    // Where normal sequencing would go on this edge; also what an emergency
    // entry saves, so the interrupted phase resumes without losing a cycle.
    state_t           seq_state;
    logic [CNT_W-1:0] seq_cnt;
    logic             aspect_conflict;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RED;
            counter     <= '0;
            saved_state <= S_RED;
            saved_cnt   <= '0;
            blink       <= 1'b0;
        end else begin
            state       <= state_n;
            counter     <= counter_n;
            saved_state <= saved_state_n;
            saved_cnt   <= saved_cnt_n;
            blink       <= blink_n;
        end
    end

    // Normal phase sequencing: RED -> LEFT -> GREEN -> YELLOW -> RED.
    always_comb begin
        // NOTE: defaults first on every combinational output so no path
        // through the case leaves a signal unassigned and infers a latch.
        seq_state = state;
        seq_cnt   = counter + CNT_W'(1);
        unique case (state)
            S_RED:    if (counter == RED_LAST)    begin seq_state = S_LEFT;   seq_cnt = '0; end
            S_LEFT:   if (counter == LEFT_LAST)   begin seq_state = S_GREEN;  seq_cnt = '0; end
            S_GREEN:  if (counter == GREEN_LAST)  begin seq_state = S_YELLOW; seq_cnt = '0; end
            S_YELLOW: if (counter == YELLOW_LAST) begin seq_state = S_RED;    seq_cnt = '0; end
            default:  seq_cnt = counter;
        endcase
    end

    // Both approaches non-red at once. EW out is decoded from registered
    // state, so this is a sampled check of ns_out only at clock edges.
    assign aspect_conflict = (ns_out != ASPECT_RED) && (out != ASPECT_RED);

    // Next-state selection, priority: conflict > emergency > sequencing.
    always_comb begin
        state_n       = state;
        counter_n     = counter;
        saved_state_n = saved_state;
        saved_cnt_n   = saved_cnt;
        blink_n       = blink;

        if (state == S_FAULT) begin
            // Terminal until reset; inputs are ignored, red just flashes.
            blink_n = ~blink;
        end else if (aspect_conflict) begin
            state_n   = S_FAULT;
            counter_n = '0;
            blink_n   = 1'b1;      // first FAULT cycle shows red lit
        end else if (state == S_ALLSTOP) begin
            if (!emergency) begin
                state_n   = saved_state;
                counter_n = saved_cnt;
            end
        end else if (emergency) begin
            saved_state_n = seq_state;
            saved_cnt_n   = seq_cnt;
            state_n       = S_ALLSTOP;
            counter_n     = '0;
        end else begin
            state_n   = seq_state;
            counter_n = seq_cnt;
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        out = ASPECT_RED;
        unique case (state)
            S_LEFT:   out = ASPECT_LEFT;
            S_GREEN:  out = ASPECT_GREEN;
            S_YELLOW: out = ASPECT_YELLOW;
            S_FAULT:  out = {3'b000, blink};
            default:  out = ASPECT_RED;
        endcase
    end

    assign phase    = state;
    assign conflict = (state == S_FAULT);

endmodule

// File: tb/tb_trafficlight_ew.sv
// -----------------------------------------------------------------------------
// tb_trafficlight_ew
//
// Directed bench for trafficlight_ew. A plan-position model (0..35 plus an
// allstop flag) produces both the North-South drive fed to the DUT and the
// expected East-West aspect, phase and conflict flag.
// -----------------------------------------------------------------------------
module tb_trafficlight_ew;

    logic       clk;
    logic       rst_n;
    logic       emergency;
    logic [3:0] ns_out;
    logic [3:0] out;
    logic [2:0] phase;
    logic       conflict;

    int n_total = 0;
    int n_pass  = 0;

    // Reference plan model.
    int pos;
    bit stop;
    bit ns_force;

    trafficlight_ew dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .emergency (emergency),
        .ns_out    (ns_out),
        .out       (out),
        .phase     (phase),
        .conflict  (conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] ew_exp_out();
        if (stop)      return 4'b0001;
        if (pos < 18)  return 4'b0001;
        if (pos < 23)  return 4'b1001;
        if (pos < 33)  return 4'b0100;
        return 4'b0010;
    endfunction

    function automatic logic [3:0] ew_exp_phase();
        if (stop)      return 4'd4;
        if (pos < 18)  return 4'd0;
        if (pos < 23)  return 4'd1;
        if (pos < 33)  return 4'd2;
        return 4'd3;
    endfunction

    function automatic logic [3:0] ns_aspect();
        if (stop)      return 4'b0001;
        if (pos < 5)   return 4'b1001;
        if (pos < 15)  return 4'b0100;
        if (pos < 18)  return 4'b0010;
        return 4'b0001;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // One clock: emergency is sampled at the edge, the model advances with the
    // same sampled value, and ns_out is re-driven 1 time unit after the edge.
    task automatic tick();
        logic e;
        e = emergency;
        @(posedge clk);
        #1;
        if (stop) begin
            if (!e) stop = 1'b0;
        end else begin
            pos = (pos + 1) % 36;
            if (e) stop = 1'b1;
        end
        if (!ns_force) ns_out = ns_aspect();
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s.out@%0d", tag, pos), out, ew_exp_out());
        check($sformatf("%s.phase@%0d", tag, pos), {1'b0, phase}, ew_exp_phase());
        check($sformatf("%s.conflict@%0d", tag, pos), {3'b000, conflict}, 4'd0);
    endtask

    task automatic tick_check(input string tag);
        tick();
        check_model(tag);
    endtask

    task automatic model_reset();
        pos      = 0;
        stop     = 1'b0;
        ns_force = 1'b0;
        ns_out   = ns_aspect();
    endtask

    initial begin
        emergency = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #1;
        check("reset.out", out, 4'b0001);
        check("reset.phase", {1'b0, phase}, 4'd0);
        check("reset.conflict", {3'b000, conflict}, 4'd0);
        #11;
        rst_n = 1'b1;   // released between edges

        // Test 1: one full plan period plus wrap back to RED.
        check_model("t1");
        for (int i = 0; i < 36; i++) tick_check("t1");
        check("t1.wrap_red", out, 4'b0001);

        // Test 2: emergency for 3 edges at GREEN counter 4 (plan position 27).
        while (pos != 27) tick_check("t2.pre");
        check("t2.green_c4", out, 4'b0100);
        emergency = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_check("t2.stop");
            check($sformatf("t2.allstop_phase%0d", i), {1'b0, phase}, 4'd4);
            check($sformatf("t2.allstop_out%0d", i), out, 4'b0001);
        end
        emergency = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_check("t2.resume");
            check($sformatf("t2.green_rest%0d", i), out, 4'b0100);
        end
        tick_check("t2.after");
        check("t2.yellow", out, 4'b0010);

        // Test 3: single-cycle pulse on the last YELLOW cycle.
        while (pos != 35) tick_check("t3.pre");
        check("t3.last_yellow", out, 4'b0010);
        emergency = 1'b1;
        tick_check("t3.stop");
        check("t3.allstop", {1'b0, phase}, 4'd4);
        emergency = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick_check("t3.red");
            check($sformatf("t3.red%0d", i), {1'b0, phase}, 4'd0);
        end
        tick_check("t3.left");
        check("t3.left_after_red", {1'b0, phase}, 4'd1);

        // Test 4: forced NS green while EW shows green -> latched FAULT.
        while (pos != 25) tick_check("t4.pre");
        ns_force = 1'b1;
        ns_out   = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            emergency = (i % 3 == 1);
            if (i == 4) ns_out = 4'b0001;
            tick();
            check($sformatf("t4.phase%0d", i), {1'b0, phase}, 4'd5);
            check($sformatf("t4.conflict%0d", i), {3'b000, conflict}, 4'd1);
            check($sformatf("t4.out%0d", i), out, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        end
        emergency = 1'b0;

        // Test 5: reset out of FAULT, run to mid-GREEN, then async reset.
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.fault_clear", {3'b000, conflict}, 4'd0);
        #2;
        rst_n = 1'b1;
        model_reset();
        while (pos != 28) tick_check("t5.pre");
        check("t5.mid_green", out, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.async_out", out, 4'b0001);
        check("t5.async_phase", {1'b0, phase}, 4'd0);
        check("t5.async_conflict", {3'b000, conflict}, 4'd0);
        #2;
        rst_n = 1'b1;
        model_reset();
        check_model("t5.rerun");
        for (int i = 0; i < 36; i++) tick_check("t5.rerun");

        // Test 6: 500 cycles with random single-cycle emergency pulses.
        for (int i = 0; i < 500; i++) begin
            emergency = (!stop && $urandom_range(0, 11) == 0);
            tick_check("t6");
            emergency = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trafficlight_ew.md
# trafficlight_ew

East-West traffic light: the opposing-approach counterpart of the North-South light. It runs the complementary 36-cycle phase plan, so East-West moves only while North-South shows red. It supports emergency preemption with exact resume of the interrupted phase. It monitors the North-South light's output vector and latches into a flashing-red fault if both approaches ever show a non-red aspect together. It sits beside the North-South light at the intersection top level; both share `clk` and `emergency`.

## Interface
- `RED_CYC`, 18: cycles of solid red per cycle plan.
- `LEFT_CYC`, 5: cycles of left-turn + red.
- `GREEN_CYC`, 10: cycles of green.
- `YELLOW_CYC`, 3: cycles of yellow.
- `CNT_W`, 5: phase counter width; must hold max(duration) − 1.

Ports:
- `clk` input 1: clock; all state changes on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `emergency` input 1: emergency vehicle present; sampled on `clk` rising edge.
- `ns_out` input 4: the North-South light's out vector, same encoding as `out`.
- `out` output 4: light drive. [3] left turn, [2] green, [1] yellow, [0] red.
- `phase` output 3: current state encoding. RED=0, LEFT=1, GREEN=2, YELLOW=3, ALLSTOP=4, FAULT=5.
- `conflict` output 1: sticky fault flag.

## Operation
- Moore machine. `out`, `phase` and `conflict` decode from registered state only; no combinational path from inputs.
- Aspects: RED → 0001, LEFT → 1001, GREEN → 0100, YELLOW → 0010, ALLSTOP → 0001.
- FAULT aspect: `out[3:1]` = 000, `out[0]` toggles every cycle, starting at 1 in the first FAULT cycle.
- Normal sequence is RED → LEFT → GREEN → YELLOW → RED.
  - `counter` runs 0 … DUR−1 in each phase.
  - On the edge with counter = DUR−1, advance to the next phase with counter = 0.
  - Each phase displays exactly DUR cycles.
- Reset alignment: from reset, EW red covers NS left/green/yellow (cycles 0–17). EW left/green/yellow covers NS red (cycles 18–35).
- Emergency:
  - Entry: on an edge with `emergency`=1 while in RED/LEFT/GREEN/YELLOW, save the (next_state, next_counter) the machine would have loaded, then enter ALLSTOP.
  - Hold: stay in ALLSTOP while `emergency`=1.
  - Exit: on the first edge with `emergency`=0, load the saved state and counter.
  - Net effect: phases lose no display cycles, and ALLSTOP cycles are pure insertion.
- Conflict monitor:
  - Evaluated on every edge in any non-FAULT state.
  - Condition: `ns_out` ≠ 0001 and EW `out` ≠ 0001.
  - Result: next state is FAULT and `conflict` ← 1.
- Priority order: reset > conflict > emergency > normal sequencing.
- FAULT:
  - Ignores `emergency` and `ns_out`.
  - Exits only via reset.
  - `conflict` stays 1 until reset.

## Timing
- Reset (`rst_n`=0) acts immediately, without waiting for a clock edge:
  - state RED, counter 0, saved state/counter cleared to RED/0.
  - `out`=0001, `phase`=0, `conflict`=0.
- The first edge after `rst_n` deasserts counts as RED cycle 0→1. The plan period is 36 cycles.
- Emergency latency: `emergency` high at edge k gives `out`=0001 in cycle k+1.
  - A single-cycle pulse yields exactly one ALLSTOP cycle.
  - This matches the North-South light's one-cycle allstop, so the two stay aligned.
- Emergency sampled at a phase's final cycle: the saved value is the next phase at counter 0.
- Emergency re-asserted on the same edge ALLSTOP would exit: ALLSTOP persists.
- Conflict latency: detected at edge k, FAULT (`out`=0001, `conflict`=1) from cycle k+1.
- `ns_out` is sampled only at edges; glitches between edges are ignored.

## Test plan
1. Reset release, `emergency`=0, `ns_out` from a reference NS model → `out` 0001 cycles 0–17, 1001 18–22, 0100 23–32, 0010 33–35, 0001 at 36; `conflict` stays 0.
2. `emergency` high 3 edges during GREEN at counter 4 → 3 cycles of 0001 with `phase`=4, then 0100 for exactly 5 more cycles (10 green total), then YELLOW.
3. `emergency` pulse on the last YELLOW cycle → 1 ALLSTOP cycle, then RED for the full 18 cycles.
4. Force `ns_out`=0100 while EW in GREEN → next cycle `phase`=5, `conflict`=1, `out` alternates 0001/0000; `emergency` pulses have no effect; state held until reset.
5. Assert `rst_n`=0 mid-GREEN between edges → `out`=0001, `conflict`=0 immediately; after release the full sequence from test 1 repeats.
6. 500 cycles against a NS model with random single-cycle `emergency` pulses → `conflict` never asserts; every non-ALLSTOP phase duration matches its parameter.
